// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame engine and its companion blocks.
package spi_pkg;

  // Default log2 of the widest supported frame
  localparam int SPI_MAX_WIDTH_LOG = 4;

  // Widest supported frame in bits
  localparam int MAXW = 2 ** SPI_MAX_WIDTH_LOG;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_frame_engine_if.sv
// Host-side load/result bus of the SPI frame engine.
interface spi_frame_engine_if #(
  parameter int SPI_MAX_WIDTH_LOG = spi_pkg::SPI_MAX_WIDTH_LOG
) ();

  localparam int MAXW = 2 ** SPI_MAX_WIDTH_LOG;

  logic [MAXW-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [MAXW-1:0] dout;
  logic            dout_valid;
  logic            frame_done;
  logic            busy;

  // Host / register-FIFO side
  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, frame_done, busy
  );

  // Engine side
  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, frame_done, busy
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Frame bit counter: clear, increment and terminal-count against the frame length.
// Also used by the SCK generator to count edges.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int CNT_W = SPI_MAX_WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority over increment so a load always starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/spi_frame_engine_chk.sv
// Protocol checks for the SPI frame engine strobe inputs.
module spi_frame_engine_chk (
  input logic clk,
  input logic rst_n,
  input logic i_first_edge,
  input logic i_second_edge
);

  // Leading and trailing SCK strobes must never coincide
  a_single_strobe: assert property (
    @(posedge clk) disable iff (!rst_n) !(i_first_edge && i_second_edge)
  );

endmodule

// File: rtl/spi_frame_engine.sv
// SPI master shift datapath with runtime frame length, bit order and abort.
// The frame is latched at load; mosi is re-driven on the write strobe and miso
// is captured on the read strobe directly into its final bit position, so the
// received word is already right-aligned when the frame completes.
module spi_frame_engine #(
  parameter int SPI_MAX_WIDTH_LOG = spi_pkg::SPI_MAX_WIDTH_LOG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpha,
  input  logic                         lsb_first,
  input  logic [SPI_MAX_WIDTH_LOG-1:0] frame_len,
  input  logic                         sck_first_edge,
  input  logic                         sck_second_edge,
  input  logic                         spi_abort,
  output logic                         mosi,
  input  logic                         miso,
  spi_frame_engine_if.slave            host
);

  import spi_pkg::spi_state_e;
  import spi_pkg::IDLE;
  import spi_pkg::SHIFT;
  import spi_pkg::DONE;

  localparam int MAXW = 2 ** SPI_MAX_WIDTH_LOG;
  localparam int CW   = SPI_MAX_WIDTH_LOG;

  spi_state_e      r_state;
  spi_state_e      w_state_nxt;

  logic            r_cpha;
  logic            r_lsb;
  logic [CW-1:0]   r_len;
  logic [MAXW-1:0] r_tx;
  logic [CW-1:0]   r_tx_cnt;
  logic            r_first_wr;
  logic [MAXW-1:0] r_rx;
  logic [MAXW-1:0] r_dout;
  logic            r_dout_valid;
  logic            r_busy;
  logic            r_mosi;

  logic            w_load;
  logic            w_read;
  logic            w_write;
  logic            w_rd_shift;
  logic [CW-1:0]   w_cnt;
  logic            w_tc;
  logic [CW-1:0]   w_rx_idx;
  logic [CW-1:0]   w_first_idx;
  logic [CW-1:0]   w_tx_cnt_nxt;
  logic [CW-1:0]   w_tx_idx_nxt;
  logic [MAXW-1:0] w_rx_nxt;

  // Strobe roles follow the latched clock phase; read wins if both fire
  assign w_read  = r_cpha ? sck_second_edge : sck_first_edge;
  assign w_write = r_cpha ? sck_first_edge  : sck_second_edge;

  assign w_load     = (r_state == IDLE) && host.din_valid;
  assign w_rd_shift = (r_state == SHIFT) && !spi_abort && w_read;

  // Bit positions: LSB-first walks up from 0, MSB-first walks down from L-1
  assign w_first_idx  = lsb_first ? {CW{1'b0}} : frame_len;
  assign w_rx_idx     = r_lsb ? w_cnt : (r_len - w_cnt);
  assign w_tx_cnt_nxt = r_tx_cnt + CW'(1);
  assign w_tx_idx_nxt = r_lsb ? w_tx_cnt_nxt : (r_len - w_tx_cnt_nxt);

  spi_bit_counter #(
    .CNT_W (CW)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_load),
    .i_inc  (w_rd_shift),
    .i_last (r_len),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  spi_frame_engine_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_first_edge  (sck_first_edge),
    .i_second_edge (sck_second_edge)
  );

  // Receive word with the current miso bit dropped into its final position
  always_comb begin
    w_rx_nxt = r_rx;
    if (w_rd_shift) begin
      w_rx_nxt[w_rx_idx] = miso;
    end else begin
      w_rx_nxt = r_rx;
    end
  end

  // Next-state decode for the IDLE -> SHIFT -> DONE sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (host.din_valid) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (spi_abort) begin
          w_state_nxt = IDLE;
        end else if (w_read && w_tc) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Frame datapath: latch at load, shift on strobes, publish or discard at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cpha       <= 1'b0;
      r_lsb        <= 1'b0;
      r_len        <= {CW{1'b0}};
      r_tx         <= {MAXW{1'b0}};
      r_tx_cnt     <= {CW{1'b0}};
      r_first_wr   <= 1'b0;
      r_rx         <= {MAXW{1'b0}};
      r_dout       <= {MAXW{1'b0}};
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_mosi       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (host.din_valid) begin
            r_cpha     <= cpha;
            r_lsb      <= lsb_first;
            r_len      <= frame_len;
            r_tx       <= host.din;
            r_tx_cnt   <= {CW{1'b0}};
            r_first_wr <= cpha;
            r_rx       <= {MAXW{1'b0}};
            r_busy     <= 1'b1;
            r_mosi     <= host.din[w_first_idx];
          end else begin
            r_busy <= 1'b0;
            r_mosi <= 1'b0;
          end
        end
        SHIFT: begin
          if (spi_abort) begin
            r_busy <= 1'b0;
            r_mosi <= 1'b0;
          end else if (w_read) begin
            r_rx <= w_rx_nxt;
            if (w_tc) begin
              r_dout       <= w_rx_nxt;
              r_dout_valid <= 1'b1;
            end else begin
              r_dout_valid <= 1'b0;
            end
          end else if (w_write) begin
            // With cpha=1 the first bit is already on the line at load
            if (r_first_wr) begin
              r_first_wr <= 1'b0;
            end else begin
              r_tx_cnt <= w_tx_cnt_nxt;
              r_mosi   <= r_tx[w_tx_idx_nxt];
            end
          end else begin
            r_rx <= r_rx;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
        end
      endcase
    end
  end

  assign mosi            = r_mosi;
  assign host.dout       = r_dout;
  assign host.dout_valid = r_dout_valid;
  assign host.frame_done = r_dout_valid;
  assign host.busy       = r_busy;
  assign host.din_ready  = (r_state == IDLE);

endmodule

// File: tb/tb_spi_frame_engine.sv
// Scoreboard bench for spi_frame_engine: directed frames push expected words,
// an independent monitor pops and compares on every dout_valid.
module tb_spi_frame_engine;

  localparam int LOGW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [3:0] frame_len = 4'd0;
  logic       sck_first_edge = 1'b0;
  logic       sck_second_edge = 1'b0;
  logic       spi_abort = 1'b0;
  logic       mosi;
  logic       miso;
  logic       loop = 1'b0;
  logic       miso_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_push = 0;
  logic [15:0] exp_q[$];

  spi_frame_engine_if #(.SPI_MAX_WIDTH_LOG(LOGW)) bus ();

  assign miso = loop ? mosi : miso_val;

  spi_frame_engine #(.SPI_MAX_WIDTH_LOG(LOGW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpha            (cpha),
    .lsb_first       (lsb_first),
    .frame_len       (frame_len),
    .sck_first_edge  (sck_first_edge),
    .sck_second_edge (sck_second_edge),
    .spi_abort       (spi_abort),
    .mosi            (mosi),
    .miso            (miso),
    .host            (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic expbit(input logic [15:0] d, input logic l, input logic [3:0] fl, input int i);
    logic [15:0] w;
    w = d;
    return l ? w[i] : w[int'(fl) - i];
  endfunction

  task automatic tick(input logic f, input logic s);
    @(posedge clk);
    #1;
    sck_first_edge  = f;
    sck_second_edge = s;
  endtask

  // Monitor: every completed frame must match the oldest expected word
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && bus.dout_valid) begin
      n_valid++;
      check("frame_done_eq_valid", bus.frame_done, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_dout_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("dout", bus.dout, e);
      end
    end
  end

  task automatic load(input logic [15:0] d, input logic c, input logic l, input logic [3:0] fl);
    int n;
    n = 0;
    tick(1'b0, 1'b0);
    while (!bus.din_ready && n < 50) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check("din_ready_before_load", bus.din_ready, 1);
    bus.din = d;
    bus.din_valid = 1'b1;
    cpha = c;
    lsb_first = l;
    frame_len = fl;
    tick(1'b0, 1'b0);
    bus.din_valid = 1'b0;
    // Scramble config: the engine must use its latched copies
    bus.din = ~d;
    cpha = ~c;
    lsb_first = ~l;
    frame_len = ~fl;
    check("busy_after_load", bus.busy, 1);
    check("din_ready_in_shift", bus.din_ready, 0);
    check("mosi_first_bit", mosi, expbit(d, l, fl, 0));
  endtask

  // mode 0: full frame, 1: abort after 'stop' reads, 2: async reset after 'stop' reads
  task automatic run_frame(input logic [15:0] d, input logic c, input logic l, input logic [3:0] fl,
                           input int mode, input int stop, input logic [15:0] exp_v, input logic glitch);
    int len;
    len = int'(fl) + 1;
    load(d, c, l, fl);
    if (mode == 0) begin
      exp_q.push_back(exp_v);
      n_push++;
    end
    for (int i = 0; i < len; i++) begin
      if (c == 1'b0) begin
        tick(1'b1, 1'b0);
        check("mosi_bit", mosi, expbit(d, l, fl, i));
      end else begin
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("mosi_bit", mosi, expbit(d, l, fl, i));
      end
      if (i == len - 1) begin
        tick(1'b0, 1'b0);
        check("dout_valid_latency", bus.dout_valid, 1);
        check("busy_in_done", bus.busy, 1);
        tick(1'b0, 1'b0);
        check("din_ready_after_done", bus.din_ready, 1);
        check("busy_after_done", bus.busy, 0);
        check("mosi_idle", mosi, 0);
        check("dout_valid_one_cycle", bus.dout_valid, 0);
      end else if (mode == 1 && i + 1 == stop) begin
        tick(1'b0, 1'b0);
        spi_abort = 1'b1;
        tick(1'b0, 1'b0);
        spi_abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_din_ready", bus.din_ready, 1);
        check("abort_mosi", mosi, 0);
        check("abort_dout_held", bus.dout, exp_v);
        check("abort_no_valid", bus.dout_valid, 0);
        tick(1'b0, 1'b0);
        check("abort_no_valid_later", bus.dout_valid, 0);
        return;
      end else if (mode == 2 && i + 1 == stop) begin
        tick(1'b0, 1'b0);
        check("pre_reset_mosi", mosi, 1);
        check("pre_reset_busy", bus.busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mosi", mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_dout", bus.dout, exp_v);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_din_ready", bus.din_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        return;
      end else begin
        tick(1'b0, 1'b0);
        if (glitch && i == 3) begin
          bus.din = 16'h1111;
          bus.din_valid = 1'b1;
          check("glitch_din_ready", bus.din_ready, 0);
        end
        if (c == 1'b0) begin
          tick(1'b0, 1'b1);
          bus.din_valid = 1'b0;
          tick(1'b0, 1'b0);
        end else begin
          bus.din_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bus.din = 16'h0000;
    bus.din_valid = 1'b0;
    #12;
    check("reset_mosi", mosi, 0);
    check("reset_dout", bus.dout, 16'h0000);
    check("reset_dout_valid", bus.dout_valid, 0);
    check("reset_frame_done", bus.frame_done, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_din_ready", bus.din_ready, 1);
    #10;
    rst_n = 1'b1;

    // Strobes in IDLE are ignored
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("idle_mosi", mosi, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_no_valid", bus.dout_valid, 0);

    // 16-bit MSB-first loopback, cpha=0
    loop = 1'b1;
    run_frame(16'hA5C3, 1'b0, 1'b0, 4'd15, 0, 0, 16'hA5C3, 1'b0);

    // 8-bit LSB-first, cpha=1, miso held high
    loop = 1'b0;
    miso_val = 1'b1;
    run_frame(16'h1234, 1'b1, 1'b1, 4'd7, 0, 0, 16'h00FF, 1'b0);

    // Single-bit frame, miso low
    miso_val = 1'b0;
    run_frame(16'h0001, 1'b0, 1'b1, 4'd0, 0, 0, 16'h0000, 1'b0);

    // Establish dout=0xBEEF, abort the next frame, then a normal 10-bit frame
    loop = 1'b1;
    run_frame(16'hBEEF, 1'b1, 1'b0, 4'd15, 0, 0, 16'hBEEF, 1'b0);
    run_frame(16'h5A5A, 1'b0, 1'b0, 4'd15, 1, 5, 16'hBEEF, 1'b0);
    run_frame(16'hF3A5, 1'b0, 1'b0, 4'd9, 0, 0, 16'h03A5, 1'b0);

    // Load request during SHIFT is ignored
    run_frame(16'h2222, 1'b1, 1'b0, 4'd15, 0, 0, 16'h2222, 1'b1);

    // Asynchronous reset mid-frame, then a fresh frame
    run_frame(16'hFFFF, 1'b0, 1'b0, 4'd15, 2, 3, 16'h0000, 1'b0);
    run_frame(16'h0ABC, 1'b1, 1'b1, 4'd11, 0, 0, 16'h0ABC, 1'b0);

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("valid_pulse_count", n_valid, n_push);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
